// File: rtl/slime_ctrl.sv
// Lifecycle controller for one slime enemy: ALIVE -> FROZEN -> SHATTER -> DEAD -> ALIVE,
// paced by frame ticks through a single shared 9-bit frame counter.
module slime_ctrl #(
  parameter int unsigned FREEZE_FRAMES  = 180,
  parameter int unsigned THAW_WARN      = 60,
  parameter int unsigned BLINK_DIV      = 8,
  parameter int unsigned BREAK_FRAMES   = 30,
  parameter int unsigned RESPAWN_FRAMES = 300
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_frame_tick,
  input  logic       i_ice_hit,
  input  logic       i_contact,
  output logic       o_isfrozen,
  output logic       o_active,
  output logic       o_visible,
  output logic       o_shatter,
  output logic       o_score_pulse,
  output logic       o_player_hurt,
  output logic [1:0] o_state
);

  localparam int unsigned BLINK_BIT = $clog2(BLINK_DIV);
  localparam logic [8:0] FREEZE_LD  = 9'(FREEZE_FRAMES);
  localparam logic [8:0] BREAK_LD   = 9'(BREAK_FRAMES);
  localparam logic [8:0] RESPAWN_LD = 9'(RESPAWN_FRAMES);
  localparam logic [8:0] WARN_LIM   = 9'(THAW_WARN);

  typedef enum logic [1:0] {ALIVE = 2'd0, FROZEN = 2'd1, SHATTER = 2'd2, DEAD = 2'd3} state_t;

  state_t     r_state, w_nstate;
  logic [8:0] r_cnt, w_ncnt;
  logic       r_contact_d;
  logic       w_dec, w_last, w_hurt, w_score, w_nvis;

  assign w_dec  = i_frame_tick && (r_cnt != 9'd0);
  assign w_last = i_frame_tick && (r_cnt == 9'd1);

  always_comb begin
    w_nstate = r_state;
    w_ncnt   = w_dec ? r_cnt - 9'd1 : r_cnt;
    w_hurt   = 1'b0;
    w_score  = 1'b0;
    unique case (r_state)
      ALIVE: begin
        if (i_ice_hit) begin
          w_nstate = FROZEN;
          w_ncnt   = FREEZE_LD;
        end else begin
          w_hurt = i_contact && !r_contact_d;
        end
      end
      FROZEN: begin
        // contact level shatters even when an ice hit lands the same cycle
        if (i_contact) begin
          w_nstate = SHATTER;
          w_ncnt   = BREAK_LD;
          w_score  = 1'b1;
        end else if (i_ice_hit) begin
          w_ncnt   = FREEZE_LD;
        end else if (w_last) begin
          w_nstate = ALIVE;
          w_ncnt   = 9'd0;
        end
      end
      SHATTER: begin
        if (w_last) begin
          w_nstate = DEAD;
          w_ncnt   = RESPAWN_LD;
        end
      end
      DEAD: begin
        if (w_last) begin
          w_nstate = ALIVE;
          w_ncnt   = 9'd0;
        end
      end
      default: ;
    endcase
  end

  // Outputs are registered from next-state values so they move with the transition edge.
  always_comb begin
    w_nvis = 1'b1;
    if (w_nstate == DEAD)
      w_nvis = 1'b0;
    else if (w_nstate == FROZEN && w_ncnt <= WARN_LIM)
      w_nvis = w_ncnt[BLINK_BIT];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= ALIVE;
      r_cnt         <= 9'd0;
      r_contact_d   <= 1'b0;
      o_isfrozen    <= 1'b0;
      o_active      <= 1'b1;
      o_visible     <= 1'b1;
      o_shatter     <= 1'b0;
      o_score_pulse <= 1'b0;
      o_player_hurt <= 1'b0;
    end else begin
      r_state       <= w_nstate;
      r_cnt         <= w_ncnt;
      r_contact_d   <= i_contact;
      o_isfrozen    <= (w_nstate == FROZEN);
      o_active      <= (w_nstate == ALIVE) || (w_nstate == FROZEN);
      o_visible     <= w_nvis;
      o_shatter     <= (w_nstate == SHATTER);
      o_score_pulse <= w_score;
      o_player_hurt <= w_hurt;
    end
  end

  assign o_state = r_state;

endmodule

// File: doc/slime_ctrl.md
# slime_ctrl

Lifecycle controller for one slime enemy. Sequences the slime through alive, frozen, shattering and dead/respawn phases, frame by frame. Drives the `isfrozen` qualifier into the slime collision detector and consumes that detector's contact output. Produces sprite-select, score and player-damage events for the render and game-state logic.

## Interface
Parameters:
- FREEZE_FRAMES, 180: frames a slime stays frozen after an ice hit (3 s at 60 Hz).
- THAW_WARN, 60: final frozen frames during which the sprite blinks.
- BLINK_DIV, 8: frames per blink half-period; power of two.
- BREAK_FRAMES, 30: frames the shatter animation is shown.
- RESPAWN_FRAMES, 300: frames dead before respawn.
- All frame counts are 1..511.

Ports:
- clk, input, 1: system clock; all state changes on its rising edge.
- rst, input, 1: asynchronous, active-high reset.
- frame_tick, input, 1: one-cycle pulse at each frame start.
- ice_hit, input, 1: ice projectile overlaps the slime; sampled every cycle.
- contact, input, 1: player/slime overlap level from the collision detector.
- isfrozen, output, 1: high in FROZEN; feeds the detector.
- active, output, 1: slime is collidable (ALIVE or FROZEN).
- visible, output, 1: draw the slime sprite.
- shatter, output, 1: select the shatter sprite.
- score_pulse, output, 1: one-cycle pulse on entering SHATTER.
- player_hurt, output, 1: one-cycle pulse on a new contact while ALIVE.
- state, output, 2: 0 ALIVE, 1 FROZEN, 2 SHATTER, 3 DEAD.

## Operation
- There is one 9-bit frame counter `cnt`. It decrements only on a `frame_tick` cycle, and only when it is nonzero.
- `contact_d` registers `contact` for rising-edge detection.
- ALIVE:
  - `ice_hit` moves to FROZEN and loads `cnt`=FREEZE_FRAMES.
  - Otherwise, a rising edge of `contact` (`contact` & ~`contact_d`) pulses `player_hurt`.
  - A held `contact` produces no further pulses.
- FROZEN:
  - `contact` (level, not edge) moves to SHATTER, loads `cnt`=BREAK_FRAMES and pulses `score_pulse`.
  - Else `ice_hit` reloads `cnt`=FREEZE_FRAMES (refreeze) and stays in FROZEN.
  - Else, a `frame_tick` with `cnt`==1 moves to ALIVE (thaw) and sets `cnt`=0.
- SHATTER: a `frame_tick` with `cnt`==1 moves to DEAD and loads `cnt`=RESPAWN_FRAMES. `ice_hit` and `contact` are ignored.
- DEAD: a `frame_tick` with `cnt`==1 moves to ALIVE. Inputs are ignored.
- Priority in a single cycle:
  - ALIVE: `ice_hit` beats `contact`; no hurt pulse that cycle.
  - FROZEN: `contact` beats `ice_hit`, which beats expiry.
- `visible`:
  - 1 in ALIVE and SHATTER; 0 in DEAD.
  - In FROZEN: 1 while `cnt` > THAW_WARN.
  - In FROZEN with `cnt` ≤ THAW_WARN: equals bit log2(BLINK_DIV) of `cnt`.
- `isfrozen` = (state==FROZEN). `active` = (state==ALIVE or FROZEN). `shatter` = (state==SHATTER).
- `player_hurt` never asserts outside ALIVE. Re-entering ALIVE with `contact` already high causes no hurt pulse unless `contact` falls and rises again.

## Timing
- All outputs are registered; each reflects an input event on the cycle after it.
- `state` and the state-derived outputs change on the same edge as the transition.
- Reset (async, any time, including mid-shatter): state=ALIVE, `cnt`=0, `contact_d`=0.
  - Outputs at reset: `isfrozen`=0, `active`=1, `visible`=1, `shatter`=0, `score_pulse`=0, `player_hurt`=0, `state`=0.
  - Release is synchronous to the next clk edge.
- Frozen duration is exactly FREEZE_FRAMES `frame_tick`s after entry, counted from the first tick after the load cycle. The same rule applies to BREAK_FRAMES and RESPAWN_FRAMES.
- A `frame_tick` on the same cycle as a counter load does not decrement the new value.
- `score_pulse` and `player_hurt` are exactly 1 cycle wide and never assert on the same cycle.

## Test plan
- Reset mid-FROZEN (`cnt`≈100) → next cycle `state`=0, `visible`=1, `isfrozen`=0, `active`=1; pulses stay 0.
- `ice_hit` 1 cycle in ALIVE, then 180 `frame_tick`s with no contact:
  - `isfrozen`=1 for exactly 180 ticks.
  - `visible` toggles every 8 ticks from `cnt`=60 down.
  - Returns to ALIVE on the 180th tick.
- Frozen, then `contact` held 3 cycles with `ice_hit` on the first cycle:
  - SHATTER entered on the first cycle; `score_pulse` high exactly 1 cycle.
  - After 30 ticks: DEAD, `visible`=0.
  - After 300 more ticks: ALIVE, `visible`=1.
- ALIVE, `contact` held 50 cycles then low 1 cycle then high → exactly 2 `player_hurt` pulses.
- ALIVE, `ice_hit` and `contact` rising on the same cycle → FROZEN, no `player_hurt`.
- Frozen, `ice_hit` at `cnt`=5 → `cnt` reloads to 180; thaw occurs 180 ticks later; `visible` returns to 1 immediately.
